// File: rtl/oam_dma_ctrl.sv
// Sprite-memory DMA controller: a CPU write to the trigger register stalls the
// CPU and copies one 256-byte page to the OAM data port, one read/write pair per byte.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR     = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rnw,
  input  logic [7:0]  mem_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_rnw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        cyc_odd;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_byte;
  logic        start;

  // Triggers are only honoured while idle, so writes during a transfer are dropped.
  assign start = (state == IDLE) && (cpu_addr == TRIG_ADDR) && !cpu_rnw;

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cyc_odd   <= 1'b0;
      page      <= 8'h00;
      idx       <= 8'h00;
      data_byte <= 8'h00;
    end else begin
      state   <= state_next;
      cyc_odd <= ~cyc_odd;
      if (start) begin
        page <= cpu_dout;
        idx  <= 8'h00;
      end
      if (state == READ) begin
        data_byte <= mem_din;
      end
      if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    bus_addr   = cpu_addr;
    bus_dout   = cpu_dout;
    bus_rnw    = cpu_rnw;
    dma_active = 1'b1;
    case (state)
      IDLE: begin
        dma_active = 1'b0;
        if (start) begin
          state_next = HALT;
        end
      end
      HALT: begin
        bus_addr   = {page, 8'h00};
        bus_dout   = data_byte;
        bus_rnw    = 1'b1;
        // Reads must land on even cycles; an extra ALIGN cycle fixes the phase.
        state_next = cyc_odd ? READ : ALIGN;
      end
      ALIGN: begin
        bus_addr   = {page, 8'h00};
        bus_dout   = data_byte;
        bus_rnw    = 1'b1;
        state_next = READ;
      end
      READ: begin
        bus_addr   = {page, idx};
        bus_dout   = data_byte;
        bus_rnw    = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_dout   = data_byte;
        bus_rnw    = 1'b0;
        state_next = (idx == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cpu_rdy = !dma_active;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: table-driven idle vectors, directed
// transfers (parity, retrigger, page FF, reset abort) and randomized transfers.
module tb_oam_dma_ctrl;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rnw;
  logic [7:0]  mem_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rnw;
  logic        cpu_rdy;
  logic        dma_active;

  logic [7:0]  key = 8'h5A;
  int          cnt;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk_ph1 = ~clk_ph1;

  // Source memory: each byte is its low address byte XOR a key.
  assign mem_din = bus_addr[7:0] ^ key;

  // Cycle index since reset release; its parity is the expected cyc_odd.
  always @(posedge clk_ph1 or negedge rst) begin
    if (!rst) cnt <= 0;
    else      cnt <= cnt + 1;
  end

  oam_dma_ctrl #(.TRIG_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
    .clk_ph1    (clk_ph1),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_rnw    (cpu_rnw),
    .mem_din    (mem_din),
    .bus_addr   (bus_addr),
    .bus_dout   (bus_dout),
    .bus_rnw    (bus_rnw),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rnw;
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout;
    logic        exp_rnw;
    logic        exp_active_next;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  dout;
    bit          chk_dout;
    bit          data_read;
  } op_t;

  op_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs(input bit force_read);
    cpu_addr = 16'($urandom);
    cpu_dout = 8'($urandom);
    cpu_rnw  = force_read ? 1'b1 : 1'($urandom);
    if (cpu_addr == TRIG) cpu_rnw = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input bit force_read);
    for (int i = 0; i < n; i++) begin
      idle_inputs(force_read);
      @(negedge clk_ph1);
      chk("idle_passthru", 32'({bus_addr, bus_dout, bus_rnw}), 32'({cpu_addr, cpu_dout, cpu_rnw}));
      chk("idle_rdy_active", 32'({cpu_rdy, dma_active}), 32'(2'b10));
      @(posedge clk_ph1); #1;
    end
  endtask

  task automatic do_abort();
    int bad;
    #1 rst = 1'b0;
    #1;
    chk("abort_active", 32'(dma_active), 32'(0));
    chk("abort_rdy", 32'(cpu_rdy), 32'(1));
    chk("abort_passthru", 32'({bus_addr, bus_dout, bus_rnw}), 32'({cpu_addr, cpu_dout, cpu_rnw}));
    @(posedge clk_ph1);
    @(negedge clk_ph1);
    rst = 1'b1;
    @(posedge clk_ph1); #1;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      idle_inputs(1'b0);
      @(negedge clk_ph1);
      if (dma_active || (!bus_rnw && bus_addr == OAM && cpu_addr != OAM)) bad++;
      @(posedge clk_ph1); #1;
    end
    chk("post_abort_quiet", 32'(bad), 32'(0));
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic run_dma(input logic [7:0] pg, input int retrig_at, input int abort_at);
    int  k, nwr, exp_stall;
    bit  halt_odd;
    op_t op;
    cpu_addr = TRIG; cpu_rnw = 1'b0; cpu_dout = pg;
    @(negedge clk_ph1);
    chk("trig_passthru", 32'({bus_addr, bus_dout, bus_rnw}), 32'({TRIG, pg, 1'b0}));
    chk("trig_rdy", 32'(cpu_rdy), 32'(1));
    halt_odd  = ((cnt + 1) % 2) == 1;
    exp_stall = halt_odd ? 513 : 514;
    exp_q.delete();
    for (int d = 0; d < (halt_odd ? 1 : 2); d++) exp_q.push_back('{{pg, 8'h00}, 1'b1, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{{pg, 8'(i)}, 1'b1, 8'h00, 1'b0, 1'b1});
      exp_q.push_back('{OAM, 1'b0, 8'(i) ^ key, 1'b1, 1'b0});
    end
    @(posedge clk_ph1); #1;
    idle_inputs(1'b0);
    k = 0; nwr = 0;
    while (k < 600) begin
      @(negedge clk_ph1);
      if (!dma_active) break;
      if (k < exp_q.size()) begin
        op = exp_q[k];
        chk("dma_bus_addr", 32'(bus_addr), 32'(op.addr));
        chk("dma_bus_rnw", 32'(bus_rnw), 32'(op.rnw));
        if (op.chk_dout) chk("dma_bus_dout", 32'(bus_dout), 32'(op.dout));
        if (op.data_read) chk("read_parity", 32'(cnt % 2), 32'(0));
      end else begin
        chk("dma_overrun", 32'(k), 32'(exp_q.size()));
      end
      chk("stall_rdy", 32'(cpu_rdy), 32'(0));
      if (!bus_rnw && bus_addr == OAM) nwr++;
      k++;
      if (abort_at > 0 && nwr == abort_at) begin
        do_abort();
        return;
      end
      @(posedge clk_ph1); #1;
      if (k == retrig_at) begin
        cpu_addr = TRIG; cpu_rnw = 1'b0; cpu_dout = pg + 8'd1;
      end else begin
        idle_inputs(1'b0);
      end
    end
    chk("stall_len", 32'(k), 32'(exp_stall));
    chk("write_count", 32'(nwr), 32'(256));
    chk("end_rdy", 32'(cpu_rdy), 32'(1));
    chk("end_passthru", 32'({bus_addr, bus_dout, bus_rnw}), 32'({cpu_addr, cpu_dout, cpu_rnw}));
    @(posedge clk_ph1); #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h4014, 8'h00, 1'b1, 16'h4014, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{16'h4013, 8'h55, 1'b0, 16'h4013, 8'h55, 1'b0, 1'b0};
    vecs[2] = '{16'h4015, 8'hAA, 1'b0, 16'h4015, 8'hAA, 1'b0, 1'b0};
    vecs[3] = '{16'h2004, 8'h12, 1'b0, 16'h2004, 8'h12, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 8'hFF, 1'b1, 16'h0000, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 8'h01, 1'b0, 16'hFFFF, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{16'hC014, 8'h02, 1'b0, 16'hC014, 8'h02, 1'b0, 1'b0};
    vecs[7] = '{16'h4014, 8'h33, 1'b1, 16'h4014, 8'h33, 1'b1, 1'b0};

    rst = 1'b0;
    cpu_addr = 16'h1234; cpu_dout = 8'h9C; cpu_rnw = 1'b1;
    #3;
    chk("rst_rdy", 32'(cpu_rdy), 32'(1));
    chk("rst_active", 32'(dma_active), 32'(0));
    chk("rst_passthru", 32'({bus_addr, bus_dout, bus_rnw}), 32'({16'h1234, 8'h9C, 1'b1}));
    repeat (2) @(posedge clk_ph1);
    @(negedge clk_ph1);
    rst = 1'b1;
    @(posedge clk_ph1); #1;

    idle_cycles(10, 1'b1);

    for (int v = 0; v < 8; v++) begin
      cpu_addr = vecs[v].addr; cpu_dout = vecs[v].dout; cpu_rnw = vecs[v].rnw;
      @(negedge clk_ph1);
      chk("vec_bus", 32'({bus_addr, bus_dout, bus_rnw}),
          32'({vecs[v].exp_addr, vecs[v].exp_dout, vecs[v].exp_rnw}));
      @(posedge clk_ph1); #1;
      cpu_addr = 16'h0000; cpu_rnw = 1'b1;
      @(negedge clk_ph1);
      chk("vec_no_trigger", 32'(dma_active), 32'(vecs[v].exp_active_next));
      @(posedge clk_ph1); #1;
    end

    // Trigger once in an even cycle and once in an odd cycle.
    for (int p = 0; p < 2; p++) begin
      if ((cnt % 2) != p) idle_cycles(1, 1'b0);
      run_dma(8'h02, -1, -1);
    end

    run_dma(8'h02, 100, -1);
    idle_cycles(3, 1'b0);
    run_dma(8'hFF, -1, -1);
    run_dma(8'h02, -1, 40);
    run_dma(8'h07, -1, -1);

    for (int r = 0; r < 8; r++) begin
      key = 8'($urandom);
      idle_cycles($urandom_range(0, 5), 1'b0);
      run_dma(8'($urandom), ($urandom % 2 == 1) ? int'($urandom_range(1, 500)) : -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
